// File: rtl/bp_pkg.sv
// Shared helpers for the branch target buffer.
// These helpers split a PC into its table index and tag, and give the reset value of an allocated counter.
package bp_pkg;

  function automatic logic [63:0] cnt_weak_taken(input int cnt_w);
    return 64'd1 << (cnt_w - 1);
  endfunction

  function automatic logic [63:0] idx_of(input logic [63:0] pc, input int idx_w);
    return pc & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] pc, input int idx_w, input int tag_w);
    return (pc >> idx_w) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational next-state of an up/down saturating counter.
// If increment and decrement are both asserted, increment wins.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_cnt,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_next
);

  always_comb begin
    o_next = i_cnt;
    if (i_inc) begin
      if (i_cnt != '1) o_next = i_cnt + W'(1);
    end else if (i_dec) begin
      if (i_cnt != '0) o_next = i_cnt - W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Tagged, direct-mapped branch target buffer with zero-latency lookup, an EX-stage update port
// and a registered mispredict/redirect toward the PC mux.
module btb_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int BYPASS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [CNT_W-1:0] pred_state,
  input  logic             bp_clear,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [31:0]      br_count,
  output logic [31:0]      mp_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(cnt_weak_taken(CNT_W));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  target;
  } entry_t;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];

  logic             r_mispredict;
  logic [PC_W-1:0]  r_redirect_pc;
  logic [31:0]      r_br_count;
  logic [31:0]      r_mp_count;

  logic [IDX_W-1:0] w_if_idx, w_ex_idx;
  logic [TAG_W-1:0] w_if_tag, w_ex_tag;
  entry_t           w_if_old, w_ex_old, w_ex_new, w_look;
  logic             w_ex_hit, w_wr;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_mp;
  logic [PC_W-1:0]  w_redirect_next;
  logic [31:0]      w_br_next, w_mp_next;

  assign w_if_idx = IDX_W'(idx_of(64'(if_pc), IDX_W));
  assign w_ex_idx = IDX_W'(idx_of(64'(ex_pc), IDX_W));
  assign w_if_tag = TAG_W'(tag_of(64'(if_pc), IDX_W, TAG_W));
  assign w_ex_tag = TAG_W'(tag_of(64'(ex_pc), IDX_W, TAG_W));

  assign w_if_old = '{valid: r_valid[w_if_idx], tag: r_tag[w_if_idx],
                      cnt: r_cnt[w_if_idx], target: r_target[w_if_idx]};
  assign w_ex_old = '{valid: r_valid[w_ex_idx], tag: r_tag[w_ex_idx],
                      cnt: r_cnt[w_ex_idx], target: r_target[w_ex_idx]};
  assign w_ex_hit = w_ex_old.valid && (w_ex_old.tag == w_ex_tag);

  sat_counter #(.W(CNT_W)) u_entry_cnt (
    .i_cnt  (w_ex_old.cnt),
    .i_inc  (ex_taken),
    .i_dec  (!ex_taken),
    .o_next (w_cnt_next)
  );

  always_comb begin
    w_ex_new = w_ex_old;
    w_wr     = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        if (w_ex_hit) begin
          w_ex_new.cnt = w_cnt_next;
          if (ex_taken) w_ex_new.target = ex_target;
          w_wr = 1'b1;
        end else if (ex_taken) begin
          w_ex_new = '{valid: 1'b1, tag: w_ex_tag, cnt: CNT_WEAK, target: ex_target};
          w_wr     = 1'b1;
        end
      end else if (ex_pred_taken) begin
        // A non-branch that was predicted taken aliases a stale entry; drop it.
        w_ex_new.valid = 1'b0;
        w_wr           = 1'b1;
      end
    end
  end

  always_comb begin
    w_look = w_if_old;
    if ((BYPASS != 0) && w_wr && (w_ex_idx == w_if_idx)) w_look = w_ex_new;
  end

  assign pred_hit    = w_look.valid && (w_look.tag == w_if_tag);
  assign pred_taken  = pred_hit && w_look.cnt[CNT_W-1];
  assign pred_target = pred_taken ? w_look.target : if_pc + PC_W'(1);
  assign pred_state  = pred_hit ? w_look.cnt : '0;

  assign w_mp = ex_valid &&
                ((ex_is_branch && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)))) ||
                 (!ex_is_branch && ex_pred_taken));
  assign w_redirect_next = (ex_is_branch && ex_taken) ? ex_target : ex_pc + PC_W'(1);

  sat_counter #(.W(32)) u_br_count (
    .i_cnt  (r_br_count),
    .i_inc  (ex_valid && ex_is_branch),
    .i_dec  (1'b0),
    .o_next (w_br_next)
  );

  sat_counter #(.W(32)) u_mp_count (
    .i_cnt  (r_mp_count),
    .i_inc  (w_mp),
    .i_dec  (1'b0),
    .o_next (w_mp_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= '0;
      end
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
      r_br_count    <= '0;
      r_mp_count    <= '0;
    end else begin
      if (w_wr) begin
        r_valid[w_ex_idx]  <= w_ex_new.valid;
        r_tag[w_ex_idx]    <= w_ex_new.tag;
        r_cnt[w_ex_idx]    <= w_ex_new.cnt;
        r_target[w_ex_idx] <= w_ex_new.target;
      end
      // Placed after the update so a same-edge clear overrides the written valid bit.
      if (bp_clear) begin
        for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
      end
      r_mispredict <= w_mp;
      if (w_mp) r_redirect_pc <= w_redirect_next;
      r_br_count <= w_br_next;
      r_mp_count <= w_mp_next;
    end
  end

  assign mispredict  = r_mispredict;
  assign redirect_pc = r_redirect_pc;
  assign br_count    = r_br_count;
  assign mp_count    = r_mp_count;

endmodule
